// File: rtl/alsu_pkg.sv
// ============================================================================
// alsu_pkg : shared encodings and default width for the ALSU front-end
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package alsu_pkg;

    localparam int ALSU_W = 16;

    typedef enum logic [2:0] {
        FUNC_ADD = 3'd0,
        FUNC_SUB = 3'd1,
        FUNC_SHL = 3'd2,
        FUNC_SHR = 3'd3,
        FUNC_AND = 3'd4,
        FUNC_XOR = 3'd5,
        FUNC_NOT = 3'd6,
        FUNC_INC = 3'd7
    } alsu_func_e;

endpackage

`default_nettype wire

// File: rtl/alsu_core.sv
// ============================================================================
// alsu_core : combinational arithmetic-logic-shift function with Z/N/C flags
//             (signed-overflow flag V when ALSU_OVF_EN is defined)
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module alsu_core
    import alsu_pkg::*;
#(
    parameter int W = ALSU_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   func,
`ifdef ALSU_OVF_EN
    output logic         v,
`endif
    output logic [W-1:0] r,
    output logic         z,
    output logic         n,
    output logic         c
);

    // One extra bit holds the carry out (ADD/INC) or the borrow (SUB)
    logic [W:0] sum;

    always_comb begin
        sum = '0;
        r   = '0;
        c   = 1'b0;
        case (func)
            FUNC_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[W-1:0];
                c   = sum[W];
            end
            FUNC_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                r   = sum[W-1:0];
                c   = sum[W];
            end
            FUNC_SHL: begin
                r = {a[W-2:0], 1'b0};
                c = a[W-1];
            end
            FUNC_SHR: begin
                r = {1'b0, a[W-1:1]};
                c = a[0];
            end
            FUNC_AND: r = a & b;
            FUNC_XOR: r = a ^ b;
            FUNC_NOT: r = ~a;
            FUNC_INC: begin
                sum = {1'b0, a} + {{W{1'b0}}, 1'b1};
                r   = sum[W-1:0];
                c   = sum[W];
            end
            default: begin
                r = '0;
                c = 1'b0;
            end
        endcase
    end

    assign z = (r == '0);
    assign n = r[W-1];

`ifdef ALSU_OVF_EN
    always_comb begin
        v = 1'b0;
        case (func)
            FUNC_ADD: v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            FUNC_SUB: v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            FUNC_INC: v = (a == {1'b0, {(W-1){1'b1}}});
            default:  v = 1'b0;
        endcase
    end
`endif

endmodule

`default_nettype wire

// File: rtl/alsu_resp.sv
// ============================================================================
// alsu_resp : registered valid/ready front-end around alsu_core with
//             accumulator and accepted-operation counter.
//             Optional macro ALSU_OVF_EN adds the registered resp_v flag.
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module alsu_resp
    import alsu_pkg::*;
#(
    parameter int W     = ALSU_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_func,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic             req_use_acc,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [W-1:0]     resp_r,
    output logic             resp_z,
    output logic             resp_n,
    output logic             resp_c,
`ifdef ALSU_OVF_EN
    output logic             resp_v,
`endif
    output logic [W-1:0]     acc,
    output logic [CNT_W-1:0] op_cnt
);

    logic             resp_valid_q, resp_valid_d;
    logic [W-1:0]     resp_r_q,     resp_r_d;
    logic             resp_z_q,     resp_z_d;
    logic             resp_n_q,     resp_n_d;
    logic             resp_c_q,     resp_c_d;
    logic [W-1:0]     acc_q,        acc_d;
    logic [CNT_W-1:0] op_cnt_q,     op_cnt_d;

    logic             req_fire;
    logic             resp_fire;
    logic [W-1:0]     op_a;
    logic [W-1:0]     core_r;
    logic             core_z;
    logic             core_n;
    logic             core_c;

    // Output slot may be refilled in the same cycle it drains: no bubble
    assign req_ready = !resp_valid_q || resp_ready;
    assign req_fire  = req_valid && req_ready;
    assign resp_fire = resp_valid_q && resp_ready;
    assign op_a      = req_use_acc ? acc_q : req_a;

`ifdef ALSU_OVF_EN
    logic resp_v_q, resp_v_d;
    logic core_v;
`endif

    alsu_core #(
        .W (W)
    ) u_core (
        .a    (op_a),
        .b    (req_b),
        .func (req_func),
`ifdef ALSU_OVF_EN
        .v    (core_v),
`endif
        .r    (core_r),
        .z    (core_z),
        .n    (core_n),
        .c    (core_c)
    );

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_r_d     = resp_r_q;
        resp_z_d     = resp_z_q;
        resp_n_d     = resp_n_q;
        resp_c_d     = resp_c_q;
        acc_d        = acc_q;
        op_cnt_d     = op_cnt_q;
        if (req_fire) begin
            resp_valid_d = 1'b1;
            resp_r_d     = core_r;
            resp_z_d     = core_z;
            resp_n_d     = core_n;
            resp_c_d     = core_c;
            acc_d        = core_r;
            op_cnt_d     = op_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (resp_fire) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_r_q     <= '0;
            resp_z_q     <= 1'b0;
            resp_n_q     <= 1'b0;
            resp_c_q     <= 1'b0;
            acc_q        <= '0;
            op_cnt_q     <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_r_q     <= resp_r_d;
            resp_z_q     <= resp_z_d;
            resp_n_q     <= resp_n_d;
            resp_c_q     <= resp_c_d;
            acc_q        <= acc_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

`ifdef ALSU_OVF_EN
    always_comb begin
        resp_v_d = resp_v_q;
        if (req_fire) begin
            resp_v_d = core_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_v_q <= 1'b0;
        end else begin
            resp_v_q <= resp_v_d;
        end
    end

    assign resp_v = resp_v_q;
`endif

    assign resp_valid = resp_valid_q;
    assign resp_r     = resp_r_q;
    assign resp_z     = resp_z_q;
    assign resp_n     = resp_n_q;
    assign resp_c     = resp_c_q;
    assign acc        = acc_q;
    assign op_cnt     = op_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alsu_resp.sv
// ============================================================================
// tb_alsu_resp : self-checking bench for alsu_resp against an arithmetic
//                reference model (resp_v checked when ALSU_OVF_EN is defined)
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_alsu_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_func = 3'd0;
    logic [15:0] req_a = 16'h0;
    logic [15:0] req_b = 16'h0;
    logic        req_use_acc = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_r;
    logic        resp_z;
    logic        resp_n;
    logic        resp_c;
    logic [15:0] acc;
    logic [15:0] op_cnt;
`ifdef ALSU_OVF_EN
    logic        resp_v;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_valid, m_r, m_z, m_n, m_c, m_v, m_acc, m_cnt;

    alsu_resp #(
        .W     (16),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_func    (req_func),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_use_acc (req_use_acc),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_r      (resp_r),
        .resp_z      (resp_z),
        .resp_n      (resp_n),
        .resp_c      (resp_c),
`ifdef ALSU_OVF_EN
        .resp_v      (resp_v),
`endif
        .acc         (acc),
        .op_cnt      (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int to_signed16(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Arithmetic statement of the function rules on plain integers
    function automatic void ref_alu(input int f, input int a, input int b,
                                    output int r, output int c, output int v);
        int t;
        int sa, sb;
        sa = to_signed16(a);
        sb = to_signed16(b);
        r = 0; c = 0; v = 0;
        case (f)
            0: begin t = a + b; r = t % 65536; c = t / 65536;
                     v = (sa + sb > 32767 || sa + sb < -32768); end
            1: begin r = (a - b + 65536) % 65536; c = (a < b);
                     v = (sa - sb > 32767 || sa - sb < -32768); end
            2: begin r = (a * 2) % 65536; c = a / 32768; end
            3: begin r = a / 2; c = a % 2; end
            4: r = a & b;
            5: r = a ^ b;
            6: r = 65535 - a;
            default: begin t = a + 1; r = t % 65536; c = t / 65536; v = (a == 32767); end
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_r = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_acc = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, ".resp_valid"}, 32'(resp_valid), 32'(m_valid));
        check({pfx, ".resp_r"},     32'(resp_r),     32'(m_r));
        check({pfx, ".resp_z"},     32'(resp_z),     32'(m_z));
        check({pfx, ".resp_n"},     32'(resp_n),     32'(m_n));
        check({pfx, ".resp_c"},     32'(resp_c),     32'(m_c));
        check({pfx, ".acc"},        32'(acc),        32'(m_acc));
        check({pfx, ".op_cnt"},     32'(op_cnt),     32'(m_cnt));
`ifdef ALSU_OVF_EN
        check({pfx, ".resp_v"},     32'(resp_v),     32'(m_v));
`endif
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic step(input string pfx, input logic v, input int f, input int a,
                        input int b, input logic ua, input logic rr);
        int r, c, ov, opa;
        logic exp_ready;
        req_valid   = v;
        req_func    = 3'(f);
        req_a       = 16'(a);
        req_b       = 16'(b);
        req_use_acc = ua;
        resp_ready  = rr;
        #1;
        exp_ready = (m_valid == 0) || rr;
        check({pfx, ".req_ready"}, 32'(req_ready), 32'(exp_ready));
        if (v && exp_ready) begin
            opa = ua ? m_acc : a;
            ref_alu(f, opa, b, r, c, ov);
            m_valid = 1; m_r = r; m_c = c; m_v = ov;
            m_z = (r == 0); m_n = (r >= 32768);
            m_acc = r;
            m_cnt = (m_cnt + 1) % 65536;
        end else if (m_valid != 0 && rr) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(pfx);
        @(negedge clk);
    endtask

    logic [15:0] exp_r [8];
    logic [2:0]  exp_f [8];

    initial begin
        exp_r = '{16'h000D, 16'hFFF9, 16'h0006, 16'h0001, 16'h0002, 16'h0009, 16'hFFFC, 16'h0004};
        exp_f = '{3'b000,   3'b011,   3'b000,   3'b001,   3'b000,   3'b000,   3'b010,   3'b000};
        model_reset();

        // Reset and hold across a clock edge
        #2 rst_n = 1'b0;
        #1 check_outputs("reset");
        @(posedge clk); #1;
        check_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Function sweep, a=3 b=10, back to back
        for (int f = 0; f < 8; f++) begin
            step("sweep", 1'b1, f, 3, 10, 1'b0, 1'b1);
            check("sweep.dir_r", 32'(resp_r), 32'(exp_r[f]));
            check("sweep.dir_znc", 32'({resp_z, resp_n, resp_c}), 32'(exp_f[f]));
        end
        check("sweep.dir_cnt", 32'(op_cnt), 32'd8);
        check("sweep.dir_acc", 32'(acc), 32'h0004);

        // Backpressure: result held, new request waits, then fires on release
        step("bp_fire", 1'b1, 0, 3, 10, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("bp_hold", 1'b1, 5, 16'h1234, 16'h00FF, 1'b0, 1'b0);
            check("bp.dir_r", 32'(resp_r), 32'h000D);
        end
        step("bp_release", 1'b1, 5, 16'h1234, 16'h00FF, 1'b0, 1'b1);
        check("bp.dir_r2", 32'(resp_r), 32'h12CB);
        check("bp.dir_cnt", 32'(op_cnt), 32'd10);
        step("bp_drain", 1'b0, 0, 0, 0, 1'b0, 1'b1);

        // Boundaries
        step("inc_wrap", 1'b1, 7, 16'hFFFF, 0, 1'b0, 1'b1);
        check("inc_wrap.dir", 32'({resp_r, resp_z, resp_c}), {16'h0, 16'h0000, 2'b11});
        step("add_wrap", 1'b1, 0, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        check("add_wrap.dir", 32'({resp_r, resp_z, resp_c}), {16'h0, 16'h0000, 2'b11});
        step("sub_eq", 1'b1, 1, 5, 5, 1'b0, 1'b1);
        check("sub_eq.dir", 32'({resp_r, resp_z, resp_c}), {16'h0, 16'h0000, 2'b10});

        // Chaining through the accumulator
        step("chain_add", 1'b1, 0, 1, 2, 1'b0, 1'b1);
        check("chain.dir0", 32'(resp_r), 32'h0003);
        step("chain_inc", 1'b1, 7, 16'hFFFF, 0, 1'b1, 1'b1);
        check("chain.dir1", 32'(resp_r), 32'h0004);
        step("chain_shl", 1'b1, 2, 16'hFFFF, 0, 1'b1, 1'b1);
        check("chain.dir2", 32'(resp_r), 32'h0008);

`ifdef ALSU_OVF_EN
        step("ovf_add", 1'b1, 0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        check("ovf_add.dir", 32'({resp_r, resp_v, resp_n}), {14'h0, 16'h8000, 2'b11});
        step("ovf_sub", 1'b1, 1, 16'h8000, 16'h0001, 1'b0, 1'b1);
        check("ovf_sub.dir", 32'({resp_r, resp_v}), {15'h0, 16'h7FFF, 1'b1});
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset while a response is stalled
        step("stall_fire", 1'b1, 0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        step("stall_hold", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        check("stall.valid", 32'(resp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 4, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1);
        check("post_rst.dir_r", 32'(resp_r), 32'h3030);
        check("post_rst.dir_cnt", 32'(op_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/alsu_resp.md
Name: alsu_resp

Overview:
Registered request/response front-end for the 16-bit arithmetic-logic-shift unit. It is the responder side of the operation interface that the datapath control drives.
- Accepts one operation per cycle over a valid/ready handshake.
- Computes the result and Z/N/C flags, and holds them in an output register until the consumer takes them.
- Keeps an accumulator, so operations can chain on the previous result without a round trip through the register file.

Parameters:
W, 16, datapath width of operands, result and accumulator
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept request this cycle
req_func  in  3  0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 AND, 5 XOR, 6 NOT, 7 INC
req_a  in  W  operand A
req_b  in  W  operand B
req_use_acc  in  1  1: operand A taken from accumulator instead of req_a
resp_valid  out  1  response register holds unconsumed result
resp_ready  in  1  consumer accepts response
resp_r  out  W  result
resp_z  out  1  result == 0
resp_n  out  1  result[W-1]
resp_c  out  1  carry/borrow/shift-out
acc  out  W  accumulator (last accepted result)
op_cnt  out  CNT_W  number of requests accepted since reset

Behaviour:
- Reset (async, rst_n low): resp_valid=0, resp_r=0, resp_z=0, resp_n=0, resp_c=0, acc=0, op_cnt=0. Outputs hold these values while rst_n is low. req_ready=1 one cycle after deassertion at the latest.
- Handshakes:
  - req fire = req_valid & req_ready.
  - resp fire = resp_valid & resp_ready.
  - req_ready = !resp_valid | resp_ready (combinational). This gives full throughput with one output register and no bubble.
- Latency:
  - A request fired in cycle t appears with resp_valid=1 in cycle t+1.
  - resp_* stay stable while resp_valid=1 and resp_ready=0.
- Simultaneous resp fire and req fire: the register loads the new result, resp_valid stays 1.
- resp fire with no req fire: resp_valid clears to 0. resp_r and the flags keep their values.
- On req fire: opA = req_use_acc ? acc : req_a. The result and flags are computed in the same cycle, and the following are all registered at once:
  - resp_r, resp_z, resp_n, resp_c
  - acc <= result
  - op_cnt <= op_cnt+1, wrapping from all-ones to 0
- Function rules, computed in W+1 bits where a carry is needed:
  - ADD: r=a+b, c=carry out.
  - SUB: r=a-b mod 2^W, c=1 when a<b unsigned (borrow).
  - SHL: r=a<<1, c=a[W-1].
  - SHR: logical, r=a>>1, c=a[0].
  - AND: r=a&b, c=0.
  - XOR: r=a^b, c=0.
  - NOT: r=~a, c=0.
  - INC: r=a+1, c=carry out.
  - b is ignored for SHL, SHR, NOT and INC.
- Z and N are computed from the W-bit result for every function.
- No request is dropped. With req_valid=1 and req_ready=0, the requester holds its inputs and the block does not sample them.
- A request fired in cycle t+1 with req_use_acc=1 uses the result of the request fired in cycle t (acc bypass is not needed; acc is registered before t+1).

Optional Feature:
ALSU_OVF_EN
- Defined:
  - Adds output resp_v (1 bit) for signed overflow, reset value 0, registered with the other flags.
  - ADD: v=(a[W-1]==b[W-1]) & (r[W-1]!=a[W-1]).
  - SUB: v=(a[W-1]!=b[W-1]) & (r[W-1]!=a[W-1]).
  - INC: v=(a==0111..1).
  - All other functions: v=0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package alsu_pkg holds:
  - FUNC encodings as named constants: FUNC_ADD through FUNC_INC, 3 bits each.
  - Default width W=16.
- Sub-module alsu_core: purely combinational function, inputs a, b, func; outputs r, z, n, c (and v under ALSU_OVF_EN).
- alsu_resp contains only the handshake logic, operand mux, output register, accumulator and counter.

Test Plan:
- After reset, a=3, b=10, use_acc=0, resp_ready=1, back-to-back funcs 0..7 → responses one cycle after each request, with r (z,n,c) as follows:
  - ADD: 000D (0,0,0)
  - SUB: FFF9 (0,1,1)
  - SHL: 0006 (0,0,0)
  - SHR: 0001 (0,0,1)
  - AND: 0002 (0,0,0)
  - XOR: 0009 (0,0,0)
  - NOT: FFFC (0,1,0)
  - INC: 0004 (0,0,0)
  - After the sequence: op_cnt=8, acc=0004.
- Backpressure: fire ADD 3+10, then hold resp_ready=0 for 4 cycles with req_valid=1 → req_ready=0 and resp_r=000D stable for those cycles. Raising resp_ready → the next request fires in the same cycle and no request is lost.
- Boundaries:
  - INC a=FFFF → r=0000, z=1, c=1.
  - ADD FFFF+0001 → r=0, z=1, c=1.
  - SUB 0005-0005 → r=0, z=1, c=0.
- Chaining: ADD a=1, b=2, then INC use_acc=1, then SHL use_acc=1 (req_a=FFFF as junk) → results 0003, 0004, 0008.
- Reset mid-operation: assert rst_n=0 while resp_valid=1 and resp_ready=0 → resp_valid, resp_r, acc and op_cnt go to 0 immediately, without waiting for a clock edge.
- With ALSU_OVF_EN defined: ADD 7FFF+0001 → r=8000, v=1, n=1; SUB 8000-0001 → r=7FFF, v=1.
